mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; even, >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort of an in-flight operation.
REQ-006 funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a  input  XLEN  operand rs1, captured on the accepting edge.
REQ-008 b  input  XLEN  operand rs2, captured on the accepting edge.
REQ-009 busy  output  1  high in CALC and FIX states.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  XLEN  operation result, held stable until the next accepted start.

Function
REQ-012 States: IDLE, CALC, FIX, DONE. done is high only in DONE; busy is high only in CALC and FIX.
REQ-013 IDLE with start=1 at edge E0: latch funct3, a, b and operand signs; load magnitudes; iteration counter = 0.
REQ-014 Normal path: IDLE -> CALC at E0; counter increments once per edge while in CALC.
REQ-015 After XLEN CALC edges, CALC -> FIX; FIX -> DONE on the next edge; DONE -> IDLE unconditionally.
REQ-016 Result: done is high in the cycle after edge E0+XLEN+1, i.e. after 33 edges for XLEN=32.
REQ-017 Multiply: radix-2 shift-add over operand magnitudes; 2*XLEN-bit accumulator.
REQ-018 Multiply signedness: MULH treats a and b as signed; MULHSU treats a signed, b unsigned; MULHU and MUL treat both as unsigned magnitudes.
REQ-019 FIX negates the 2*XLEN product when the operand signs differ (signed operands only).
REQ-020 Multiply result: MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
REQ-021 Divide: restoring division, one quotient bit per CALC cycle, on magnitudes for DIV/REM and raw values for DIVU/REMU.
REQ-022 FIX sign rules: quotient is negated when the signs of a and b differ (DIV); remainder takes the sign of the dividend (REM).
REQ-023 Divide-by-zero (b == 0) goes IDLE -> DONE at E0, skipping CALC and FIX: DIV/DIVU return all ones; REM/REMU return a.
REQ-024 Signed overflow (DIV/REM, a = most-negative value, b = all ones) also goes IDLE -> DONE at E0: DIV returns a; REM returns 0.
REQ-025 start is ignored while busy or in DONE; there is no queueing.
REQ-026 flush in CALC or FIX forces IDLE on the next edge; done is not asserted; result keeps its previous value.
REQ-027 flush in IDLE has priority over start: the request is not accepted. flush in DONE has no effect.
REQ-028 Operand changes after E0 do not affect the in-flight result.
REQ-029 result updates only on the edge that enters DONE.

Reset
REQ-030 Reset asserted at any time, including mid-operation: state = IDLE; busy = 0, done = 0, result = 0, counter = 0; accumulators = 0.
REQ-031 After reset deasserts, the first start in IDLE is accepted normally; no partial result from the aborted operation is ever presented.

Verification
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done a single pulse 33 edges after start; busy high for exactly 32 cycles (31 CALC + FIX).

Correction to REQ-032: busy is high for XLEN CALC cycles plus 1 FIX cycle, i.e. 33 cycles for XLEN=32.

REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, with done one edge after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-036 start a second op while busy -> ignored; first result unchanged.
REQ-037 flush at CALC cycle 10 -> busy low after the next edge, no done, result unchanged.
REQ-038 reset pulse at CALC cycle 10 -> all outputs 0 immediately; next MUL 3 x 4 -> 12.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit.
// A request is accepted in IDLE, iterates one bit per cycle in CALC (XLEN cycles),
// applies sign correction in FIX and presents the result with a one-cycle done pulse.
// Divide-by-zero and signed overflow bypass CALC/FIX and finish right after acceptance.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request, sampled only in IDLE
//   flush   synchronous abort of an in-flight operation (beats start in IDLE)
//   funct3  M-extension operation select
//   a, b    operands rs1/rs2, captured on the accepting edge
//   busy    high in CALC and FIX
//   done    one-cycle completion pulse
//   result  operation result, held until the next completion
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [CntW-1:0]     cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic [XLEN-1:0]     result_q;

  // Operand decode on the request inputs
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] special_res;
  logic            neg_d;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && !funct3[0] && (a == MinNeg) && (b == '1);
  assign special  = div_zero || div_ovf;
  // REM/REMU return the dividend on /0; REM returns 0 on overflow, DIV returns a
  assign special_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
  // Remainder follows the dividend's sign; products and quotients follow the xor
  assign neg_d    = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  assign accept   = (state_q == StIdle) && start && !flush;

  // Multiply step: low half holds the remaining multiplier bits, high half the partial sum
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: high half is the remainder, low half shifts dividend out/quotient in
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  // Sign correction applied on the FIX edge
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: begin
        if (flush)                 state_d = StIdle;
        else if (cnt_q == CntLast) state_d = StFix;
      end
      StFix:  state_d = flush ? StIdle : StDone;
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= funct3;
        neg_q <= neg_d;
        cnt_q <= '0;
        acc_q <= {{XLEN{1'b0}}, a_mag};
        opb_q <= b_mag;
        if (special) result_q <= special_res;
      end else if (state_q == StCalc && !flush) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= op_q[2] ? div_next : mul_next;
      end else if (state_q == StFix && !flush) begin
        result_q <= fix_res;
      end
    end
  end

  assign busy   = (state_q == StCalc) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0]        p;
    logic signed [31:0] sx, sy;
    logic               ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, x} * {32'd0, y};                 return p[31:0];  end
      3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y};     return p[63:32]; end
      3'd2: begin p = {{32{x[31]}}, x} * {32'd0, y};           return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y};                 return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one op, scramble operands after acceptance, then check result/latency/busy/pulse
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    int          n, nb;
    logic [31:0] exp;
    bit          spec;
    exp  = model(f, x, y);
    spec = f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(7, 0));
    n = 0; nb = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) break;
    end
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " latency"}, 64'(n), spec ? 64'd1 : 64'(XLEN + 2));
    check({tag, " busy"}, 64'(nb), spec ? 64'd0 : 64'(XLEN + 1));
    @(negedge clk);
    check({tag, " pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          n, ndone;
    logic [2:0]  f;
    logic [31:0] x, y, held;

    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = '0; b = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'd5, 32'd0, "divu0");
    run_op(3'd7, 32'd5, 32'd0, "remu0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "removf");

    // Start while busy is ignored and not queued
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !done) begin @(negedge clk); n++; end
    check("busy-start result", 64'(result), 64'hFFFF_FFEB);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check("busy-start no queue", 64'(ndone), 64'd0);

    // Flush at CALC cycle 10
    held = result;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check("flush no done", 64'(ndone), 64'd0);
    check("flush result", 64'(result), 64'(held));

    // Flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; a = 32'd1; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("idle flush done", 64'(done), 64'd0);
    check("idle flush result", 64'(result), 64'(held));

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; funct3 = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, "post-reset mul");

    // Randomized ops with a bias toward zero divisors and small operands
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(7, 0));
      x = $urandom;
      y = $urandom;
      if (i % 5 == 0) y = 32'd0;
      if (i % 7 == 0) begin x = 32'($urandom_range(1000, 0)); y = 32'($urandom_range(20, 1)); end
      if (i % 11 == 0) x = 32'h8000_0000;
      run_op(f, x, y, "random");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
